// File: rtl/card_game_pkg.sv
// Shared constants, FSM state type and grid-to-index mapping for the card game.
package card_game_pkg;

    localparam int unsigned GRID_DIM  = 6;
    localparam int unsigned NUM_CARDS = 36;

    typedef enum logic [1:0] {
        PICK1 = 2'd0,
        PICK2 = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Cards are numbered 1..36 row-major from the top-left corner.
    function automatic logic [5:0] card_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(row) * 6'(GRID_DIM) + 6'(col) + 6'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, optional debounce, rising-edge pulse.
// Debounce is compiled in only when CARD_SELECT_DEBOUNCE_EN is defined.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetN,
    input  logic btn,
    output logic press
);

    logic [1:0] sync_q;
    logic       synced;
    logic       level_q, level_d;
    logic       press_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign synced = sync_q[1];

`ifdef CARD_SELECT_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // The counter runs only while the synchronized level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (synced != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;

    always_comb begin
        level_d = synced;
    end
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/card_select.sv
// Cursor navigation and two-card pick FSM feeding the compare stage.
// Optional button debounce selected by CARD_SELECT_DEBOUNCE_EN.
module card_select
    import card_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 btnUp,
    input  logic                 btnDown,
    input  logic                 btnLeft,
    input  logic                 btnRight,
    input  logic                 btnSel,
    input  logic [NUM_CARDS-1:0] cardMatched,
    input  logic                 resolveDone,
    output logic                 A,
    output logic                 inputState,
    output logic [5:0]           mem6x6,
    output logic [2:0]           cursorRow,
    output logic [2:0]           cursorCol,
    output logic [NUM_CARDS-1:0] faceUp
);

    localparam logic [2:0] MaxPos = 3'(GRID_DIM - 1);

    logic [4:0] btn_raw, btn_press;
    logic       up_p, down_p, left_p, right_p, sel_p;

    assign btn_raw = {btnSel, btnUp, btnDown, btnLeft, btnRight};
    assign {sel_p, up_p, down_p, left_p, right_p} = btn_press;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clock (clock),
            .resetN(resetN),
            .btn   (btn_raw[i]),
            .press (btn_press[i])
        );
    end

    state_e               state_q, state_d;
    logic                 a_q, a_d;
    logic                 is_q, is_d;
    logic [5:0]           mem_q, mem_d;
    logic [2:0]           row_q, row_d;
    logic [2:0]           col_q, col_d;
    logic [NUM_CARDS-1:0] face_q, face_d;
    logic [5:0]           first_q, first_d;

    logic [5:0] idx;
    logic [5:0] bit_sel;
    logic       legal;

    assign idx     = card_index(row_q, col_q);
    assign bit_sel = idx - 6'd1;
    assign legal   = !cardMatched[bit_sel] && !face_q[bit_sel];

    always_comb begin
        state_d = state_q;
        a_d     = 1'b0;
        is_d    = is_q;
        mem_d   = mem_q;
        row_d   = row_q;
        col_d   = col_q;
        face_d  = face_q;
        first_d = first_q;

        // Select outranks every move even when the pick itself is rejected.
        if (sel_p) begin
            case (state_q)
                PICK1: begin
                    if (legal) begin
                        a_d             = 1'b1;
                        is_d            = 1'b0;
                        mem_d           = idx;
                        face_d[bit_sel] = 1'b1;
                        first_d         = idx;
                        state_d         = PICK2;
                    end
                end
                PICK2: begin
                    if (legal && (idx != first_q)) begin
                        a_d             = 1'b1;
                        is_d            = 1'b1;
                        mem_d           = idx;
                        face_d[bit_sel] = 1'b1;
                        state_d         = WAIT;
                    end
                end
                default: ;
            endcase
        end else if (up_p) begin
            row_d = (row_q == 3'd0) ? MaxPos : row_q - 3'd1;
        end else if (down_p) begin
            row_d = (row_q == MaxPos) ? 3'd0 : row_q + 3'd1;
        end else if (left_p) begin
            col_d = (col_q == 3'd0) ? MaxPos : col_q - 3'd1;
        end else if (right_p) begin
            col_d = (col_q == MaxPos) ? 3'd0 : col_q + 3'd1;
        end

        if ((state_q == WAIT) && resolveDone) begin
            face_d  = '0;
            state_d = PICK1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= PICK1;
            a_q     <= 1'b0;
            is_q    <= 1'b0;
            mem_q   <= 6'd0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            face_q  <= '0;
            first_q <= 6'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            is_q    <= is_d;
            mem_q   <= mem_d;
            row_q   <= row_d;
            col_q   <= col_d;
            face_q  <= face_d;
            first_q <= first_d;
        end
    end

    assign A          = a_q;
    assign inputState = is_q;
    assign mem6x6     = mem_q;
    assign cursorRow  = row_q;
    assign cursorCol  = col_q;
    assign faceUp     = face_q;

endmodule

// File: tb/tb_card_select.sv
// Directed bench for card_select with a game-rule model and a per-cycle strobe checker.
module tb_card_select;

    logic        clock = 1'b0;
    logic        resetN;
    logic        btnUp, btnDown, btnLeft, btnRight, btnSel;
    logic [35:0] cardMatched;
    logic        resolveDone;
    logic        A, inputState;
    logic [5:0]  mem6x6;
    logic [2:0]  cursorRow, cursorCol;
    logic [35:0] faceUp;

    card_select #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .btnUp      (btnUp),
        .btnDown    (btnDown),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .btnSel     (btnSel),
        .cardMatched(cardMatched),
        .resolveDone(resolveDone),
        .A          (A),
        .inputState (inputState),
        .mem6x6     (mem6x6),
        .cursorRow  (cursorRow),
        .cursorCol  (cursorCol),
        .faceUp     (faceUp)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Game model: cursor, face-up set, pick phase (0 first, 1 second, 2 waiting).
    int       mrow, mcol, mphase, mfirst;
    bit [35:0] mface;
    int       exp_is[$];
    int       exp_mem[$];

    // Observed strobe history from the checker process.
    int   strobes;
    logic last_is;
    logic [5:0] last_mem;
    logic prev_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!resetN) begin
            chk("reset_A", 64'(A), 64'd0);
            chk("reset_inputState", 64'(inputState), 64'd0);
            chk("reset_mem6x6", 64'(mem6x6), 64'd0);
            last_is  = 1'b0;
            last_mem = 6'd0;
            prev_a   = 1'b0;
        end else if (A === 1'b1) begin
            chk("strobe_width", 64'(prev_a), 64'd0);
            if (exp_is.size() == 0) begin
                chk("unexpected_strobe", 64'(mem6x6), 64'd0);
            end else begin
                chk("strobe_inputState", 64'(inputState), 64'(exp_is.pop_front()));
                chk("strobe_mem6x6", 64'(mem6x6), 64'(exp_mem.pop_front()));
            end
            last_is  = inputState;
            last_mem = mem6x6;
            strobes++;
            prev_a = 1'b1;
        end else begin
            chk("hold_inputState", 64'(inputState), 64'(last_is));
            chk("hold_mem6x6", 64'(mem6x6), 64'(last_mem));
            prev_a = 1'b0;
        end
    end

    function automatic void model_reset();
        mrow = 0; mcol = 0; mphase = 0; mfirst = 0; mface = '0;
        exp_is.delete();
        exp_mem.delete();
    endfunction

    function automatic void model_sel();
        int  idx;
        bit  ok;
        idx = mrow * 6 + mcol + 1;
        ok  = !cardMatched[idx-1] && !mface[idx-1];
        if (mphase == 0 && ok) begin
            exp_is.push_back(0); exp_mem.push_back(idx);
            mface[idx-1] = 1'b1; mfirst = idx; mphase = 1;
        end else if (mphase == 1 && ok && idx != mfirst) begin
            exp_is.push_back(1); exp_mem.push_back(idx);
            mface[idx-1] = 1'b1; mphase = 2;
        end
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_row"}, 64'(cursorRow), 64'(mrow));
        chk({tag, "_col"}, 64'(cursorCol), 64'(mcol));
        chk({tag, "_faceUp"}, 64'(faceUp), 64'(mface));
        chk({tag, "_pending"}, 64'(exp_is.size()), 64'd0);
    endtask

    // b = {sel, up, down, left, right}
    task automatic press(input logic [4:0] b, input string tag);
        if (b[4]) model_sel();
        else if (b[3]) mrow = (mrow + 5) % 6;
        else if (b[2]) mrow = (mrow + 1) % 6;
        else if (b[1]) mcol = (mcol + 5) % 6;
        else if (b[0]) mcol = (mcol + 1) % 6;
        @(posedge clock); #1;
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = b;
        repeat (12) @(posedge clock);
        #1;
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = 5'b0;
        repeat (14) @(posedge clock);
        #1;
        check_quiet(tag);
    endtask

    task automatic resolve(input string tag);
        if (mphase == 2) begin
            mface = '0; mphase = 0;
        end
        @(posedge clock); #1;
        resolveDone = 1'b1;
        @(posedge clock); #1;
        resolveDone = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_quiet(tag);
    endtask

    localparam logic [4:0] SEL = 5'b10000, UP = 5'b01000, DN = 5'b00100,
                           LF = 5'b00010, RT = 5'b00001;

    int base;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = 5'b0;
        cardMatched = '0;
        resolveDone = 1'b0;
        strobes = 0;
        model_reset();
        repeat (4) @(posedge clock);
        #1;
        check_quiet("reset");
        resetN = 1'b1;
        repeat (4) @(posedge clock);

        // Wrap-around from (0,0) to (5,5), then pick card 36.
        press(LF, "left_wrap");
        press(UP, "up_wrap");
        chk("lit_row55", 64'(cursorRow), 64'd5);
        chk("lit_col55", 64'(cursorCol), 64'd5);
        press(SEL, "sel36");
        chk("lit_mem36", 64'(last_mem), 64'd36);
        chk("lit_is36", 64'(last_is), 64'd0);
        press(RT, "right_wrap");
        press(SEL, "sel31");
        resolve("resolve_a");
        chk("lit_face_clear", 64'(faceUp), 64'd0);

        // Pair (1,2) from the top-left corner.
        press(DN, "down_wrap");
        base = strobes;
        press(SEL, "sel1");
        press(RT, "right01");
        press(SEL, "sel2");
        chk("lit_two_strobes", 64'(strobes - base), 64'd2);
        chk("lit_mem2", 64'(last_mem), 64'd2);
        chk("lit_is2", 64'(last_is), 64'd1);
        chk("lit_face3", 64'(faceUp), 64'h3);
        press(SEL, "sel_in_wait");
        resolve("resolve_b");

        // Illegal picks in PICK2: repeat and matched card.
        press(LF, "left00");
        press(SEL, "sel1_again");
        base = strobes;
        press(SEL, "repeat_pick");
        cardMatched[2] = 1'b1;
        press(RT, "right01b");
        press(RT, "right02");
        press(SEL, "matched_pick");
        chk("lit_no_strobe", 64'(strobes - base), 64'd0);
        press(LF, "left01");
        press(SEL, "sel2_after_illegal");
        press(SEL, "wait_sel");
        resolve("resolve_c");
        resolve("resolve_in_pick1");
        press(RT, "right02b");
        press(SEL, "matched_in_pick1");
        press(LF, "left01b");
        press(LF, "left00b");

        // Simultaneous select and right: select wins.
        press(SEL | RT, "sel_and_right");
        chk("lit_col_unchanged", 64'(cursorCol), 64'd0);

        // Reset during PICK2 abandons the pair.
        press(RT, "right_before_reset");
        @(posedge clock); #1;
        resetN = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_quiet("in_reset");
        resetN = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check_quiet("after_reset");
        press(SEL, "sel_after_reset");

`ifdef CARD_SELECT_DEBOUNCE_EN
        base = strobes;
        resolve("resolve_noop");
        @(posedge clock); #1;
        btnSel = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        btnSel = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check_quiet("glitch");
        chk("lit_glitch_no_strobe", 64'(strobes - base), 64'd0);
`endif

        repeat (5) @(posedge clock);
        chk("final_pending", 64'(exp_is.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/card_select.md
CARD_SELECT -- requirements
Module: card_select

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable-level clocks before a button press is accepted.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 btnUp, btnDown, btnLeft, btnRight, btnSel  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 cardMatched  input  36  per-card matched flags from the compare stage; bit i is card index i+1.
REQ-006 resolveDone  input  1  single-cycle pulse from the compare stage meaning the current pair has been judged.
REQ-007 A  output  1  single-cycle pick strobe to compareCards.
REQ-008 inputState  output  1  0 = first pick, 1 = second pick; valid while A=1.
REQ-009 mem6x6  output  6  picked card index, 1..36; valid while A=1.
REQ-010 cursorRow, cursorCol  output  3 each  cursor position, 0..5, for the VGA stage.
REQ-011 faceUp  output  36  cards currently shown face-up because they were picked.

Function
REQ-012 Each button passes a 2-FF synchronizer; an action fires once, on the accepted rising edge of the press.
REQ-013 At most one action is taken per cycle, with priority btnSel > btnUp > btnDown > btnLeft > btnRight; losing edges are discarded.
REQ-014 Up/Down change cursorRow by -1/+1 and Left/Right change cursorCol by -1/+1, with wrap-around: 0 minus 1 gives 5, and 5 plus 1 gives 0.
REQ-015 Cursor moves are allowed in every FSM state.
REQ-016 The card index equals cursorRow*6 + cursorCol + 1.
REQ-017 The FSM states are PICK1, PICK2 and WAIT.
REQ-018 In PICK1, btnSel on a card that is neither matched nor face-up: in the next cycle A=1, inputState=0, mem6x6=index; faceUp bit set; index stored as firstIdx; go to PICK2.
REQ-019 In PICK2, btnSel on a card that is not matched, not face-up and not equal to firstIdx: in the next cycle A=1, inputState=1, mem6x6=index; faceUp bit set; go to WAIT.
REQ-020 A select on an illegal card, meaning one that is matched, already face-up or a repeat pick, is ignored with no strobe and no state change.
REQ-021 In WAIT, btnSel is ignored; on resolveDone all faceUp bits clear and the FSM goes to PICK1.
REQ-022 resolveDone outside WAIT is ignored.
REQ-023 A is high for exactly one cycle per accepted pick.
REQ-024 inputState and mem6x6 hold their last values while A=0.

Reset
REQ-025 While resetN=0, the block is in PICK1 with A=0, inputState=0, mem6x6=0, cursorRow=0, cursorCol=0, faceUp=0, firstIdx=0, and all synchronizer and debounce state cleared.
REQ-026 Reset asserted mid-pair abandons the pair; no strobe is emitted on reset release.

Configuration
REQ-027 With macro CARD_SELECT_DEBOUNCE_EN defined, a press is accepted only after the synchronized level has been stable for DEBOUNCE_CYCLES clocks.
REQ-028 With CARD_SELECT_DEBOUNCE_EN undefined, the synchronized rising edge is accepted immediately and DEBOUNCE_CYCLES is unused.

Structure
REQ-029 Package card_game_pkg holds GRID_DIM=6, NUM_CARDS=36, the FSM state enum (PICK1, PICK2, WAIT) and the row/col-to-index function.
REQ-030 Sub-module button_debounce (synchronizer, optional debounce, edge detect) is instantiated once per button.

Verification
REQ-031 Bench runs with DEBOUNCE_CYCLES=4 and is executed both with and without the macro defined.
REQ-032 After reset, press Left once then Up once -> cursor (5,5); Sel then gives A=1, inputState=0, mem6x6=36.
REQ-033 Sel at (0,0), Right, Sel -> two one-cycle strobes: (inputState=0, mem6x6=1) then (inputState=1, mem6x6=2); faceUp bits 0 and 1 set; FSM is in WAIT.
REQ-034 In PICK2, Sel again on firstIdx, and Sel on a card with cardMatched set -> no strobe and no state change; a third Sel in WAIT -> no strobe.
REQ-035 resolveDone pulse in WAIT -> faceUp=0 and FSM in PICK1; a resolveDone pulse in PICK1 -> no effect.
REQ-036 btnSel and btnRight rising in the same cycle -> select taken and cursor unchanged.
REQ-037 With the macro defined, a 2-cycle glitch on btnSel -> no strobe.
REQ-038 resetN low during PICK2 -> all outputs at reset values.
